// File: rtl/mezcladora_planta.sv
// Plant model for the mixer controller: turns actuator commands into tank level,
// level sensors, operator start pulses and mixing-timer expiry pulses.
module mezcladora_planta #(
  parameter int NIVEL_W     = 8,
  parameter int NIVEL_MAX   = 200,
  parameter int UMBRAL_ALTO = 160,
  parameter int UMBRAL_BAJO = 1,
  parameter int F1          = 10,
  parameter int F2          = 5,
  parameter int F3          = 20,
  parameter int FB          = 8,
  parameter int T_MEZCLA    = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Inicio,
  input  logic               V1,
  input  logic               V2,
  input  logic               V3,
  input  logic               B,
  input  logic               M,
  input  logic               T,
  input  logic               S,
  output logic               IN,
  output logic               TOK,
  output logic               P1,
  output logic               P2,
  output logic [NIVEL_W-1:0] Nivel,
  output logic               Desborde,
  output logic [15:0]        Ciclos_M
);

  localparam int SW    = NIVEL_W + 2;
  localparam int CNT_W = (T_MEZCLA > 1) ? $clog2(T_MEZCLA) : 1;

  typedef logic signed [SW-1:0] suma_t;

  localparam suma_t F1_S   = suma_t'(F1);
  localparam suma_t F2_S   = suma_t'(F2);
  localparam suma_t F3_S   = suma_t'(F3);
  localparam suma_t FB_S   = suma_t'(FB);
  localparam suma_t MAX_S  = suma_t'(NIVEL_MAX);
  localparam suma_t CERO_S = suma_t'(0);

  localparam logic [NIVEL_W-1:0] MAX_N  = NIVEL_W'(NIVEL_MAX);
  localparam logic [NIVEL_W-1:0] ALTO_N = NIVEL_W'(UMBRAL_ALTO);
  localparam logic [NIVEL_W-1:0] BAJO_N = NIVEL_W'(UMBRAL_BAJO);
  localparam logic [CNT_W-1:0]   CNT_ULT = CNT_W'(T_MEZCLA - 1);
  localparam logic [CNT_W-1:0]   CNT_UNO = CNT_W'(1);

  logic               inicio_q, inicio_d;
  logic               in_q, in_d;
  logic               tok_q, tok_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NIVEL_W-1:0] nivel_q, nivel_d;
  logic               desborde_q, desborde_d;
  logic [15:0]        ciclos_q, ciclos_d;
  suma_t              suma_s;

  // The indicator lamp has no physical effect on the tank.
  logic unused_s;
  assign unused_s = S;

  always_comb begin
    inicio_d   = Inicio;
    in_d       = Inicio & ~inicio_q;

    // Fill and drain act in the same cycle, so they net out before clamping.
    suma_s = $signed({2'b00, nivel_q})
           + (V1 ? F1_S : CERO_S) + (V2 ? F2_S : CERO_S)
           - (V3 ? F3_S : CERO_S) - (B  ? FB_S : CERO_S);

    nivel_d    = nivel_q;
    desborde_d = desborde_q;
    if (suma_s < CERO_S) begin
      nivel_d = '0;
    end else if (suma_s > MAX_S) begin
      nivel_d    = MAX_N;
      desborde_d = 1'b1;
    end else begin
      nivel_d = suma_s[NIVEL_W-1:0];
    end

    cnt_d = '0;
    tok_d = 1'b0;
    if (!T) begin
      cnt_d = '0;
      tok_d = 1'b0;
    end else if (cnt_q == CNT_ULT) begin
      cnt_d = '0;
      tok_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_UNO;
      tok_d = 1'b0;
    end

    ciclos_d = ciclos_q;
    if (M && (ciclos_q != 16'hFFFF)) begin
      ciclos_d = ciclos_q + 16'd1;
    end else begin
      ciclos_d = ciclos_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inicio_q   <= 1'b0;
      in_q       <= 1'b0;
      tok_q      <= 1'b0;
      cnt_q      <= '0;
      nivel_q    <= '0;
      desborde_q <= 1'b0;
      ciclos_q   <= 16'd0;
    end else begin
      inicio_q   <= inicio_d;
      in_q       <= in_d;
      tok_q      <= tok_d;
      cnt_q      <= cnt_d;
      nivel_q    <= nivel_d;
      desborde_q <= desborde_d;
      ciclos_q   <= ciclos_d;
    end
  end

  assign IN       = in_q;
  assign TOK      = tok_q;
  assign Nivel    = nivel_q;
  assign Desborde = desborde_q;
  assign Ciclos_M = ciclos_q;
  assign P1       = (nivel_q >= ALTO_N);
  assign P2       = (nivel_q >= BAJO_N);

endmodule

// File: tb/tb_mezcladora_planta.sv
// Closed-loop style bench for mezcladora_planta: directed and random actuator
// sequences checked by a scoreboard against a behavioural plant model.
`timescale 1ns/1ps
module tb_mezcladora_planta;

  logic       Clk, Reset;
  logic       Inicio, V1, V2, V3, B, M, T, S;
  logic       IN, TOK, P1, P2, Desborde;
  logic [7:0] Nivel;
  logic [15:0] Ciclos_M;

  mezcladora_planta dut (
    .Clk(Clk), .Reset(Reset), .Inicio(Inicio), .V1(V1), .V2(V2), .V3(V3),
    .B(B), .M(M), .T(T), .S(S), .IN(IN), .TOK(TOK), .P1(P1), .P2(P2),
    .Nivel(Nivel), .Desborde(Desborde), .Ciclos_M(Ciclos_M)
  );

  typedef struct {
    bit in_b, tok, p1, p2, desb;
    int nivel, ciclos;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural plant state
  int m_level, m_run, m_ciclos;
  bit m_desb, m_prev_inicio;

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_run = 0; m_ciclos = 0; m_desb = 0; m_prev_inicio = 0;
  endtask

  // One clock of stimulus: inputs {Inicio,V1,V2,V3,B,M,T,S}
  task automatic step(input bit [7:0] v);
    exp_t e;
    int sum;
    @(negedge Clk);
    {Inicio, V1, V2, V3, B, M, T, S} = v;
    e.in_b = v[7] && !m_prev_inicio;
    m_prev_inicio = v[7];
    sum = m_level + 10 * int'(v[6]) + 5 * int'(v[5]) - 20 * int'(v[4]) - 8 * int'(v[3]);
    if (sum < 0) m_level = 0;
    else if (sum > 200) begin m_level = 200; m_desb = 1; end
    else m_level = sum;
    m_run = v[1] ? m_run + 1 : 0;
    e.tok = v[1] && (m_run % 4 == 0);
    if (v[2] && m_ciclos < 65535) m_ciclos++;
    e.nivel = m_level; e.desb = m_desb; e.ciclos = m_ciclos;
    e.p1 = (m_level >= 160); e.p2 = (m_level >= 1);
    exp_q.push_back(e);
  endtask

  task automatic repeat_step(input bit [7:0] v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_IN"}, IN, 0);
    chk({tag, "_TOK"}, TOK, 0);
    chk({tag, "_P1"}, P1, 0);
    chk({tag, "_P2"}, P2, 0);
    chk({tag, "_Nivel"}, Nivel, 0);
    chk({tag, "_Desborde"}, Desborde, 0);
    chk({tag, "_Ciclos"}, Ciclos_M, 0);
  endtask

  // Monitor: after each edge compare the DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("IN", IN, e.in_b);
        chk("TOK", TOK, e.tok);
        chk("P1", P1, e.p1);
        chk("P2", P2, e.p2);
        chk("Nivel", Nivel, e.nivel);
        chk("Desborde", Desborde, e.desb);
        chk("Ciclos_M", Ciclos_M, e.ciclos);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    {Inicio, V1, V2, V3, B, M, T, S} = 8'h00;
    model_reset();
    #3;
    chk_zero("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Start edge: high 5, low 2, high 1
    repeat_step(8'b1000_0000, 5);
    repeat_step(8'b0000_0000, 2);
    repeat_step(8'b1000_0000, 1);
    repeat_step(8'b0000_0000, 1);

    // Fill with V1+V2 through P1 and into overflow, with the mixer running
    repeat_step(8'b0110_0100, 16);
    // Drain with V3+B down to empty
    repeat_step(8'b0001_1000, 9);

    // Timer: 9 continuous, then broken runs of 3
    repeat_step(8'b0000_0010, 9);
    repeat_step(8'b0000_0000, 1);
    repeat_step(8'b0000_0010, 3);
    repeat_step(8'b0000_0000, 1);
    repeat_step(8'b0000_0010, 3);
    repeat_step(8'b0000_0000, 1);

    // Random phases alternating fill-biased and drain-biased valve activity
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 50; i++) begin
        bit [7:0] v;
        v = 8'($urandom);
        if (ph % 2 == 0) begin
          v[6] = ($urandom_range(0, 3) != 0);
          v[4] = ($urandom_range(0, 3) == 0);
        end else begin
          v[6] = ($urandom_range(0, 3) == 0);
          v[4] = ($urandom_range(0, 3) != 0);
        end
        v[1] = ($urandom_range(0, 7) != 0);
        step(v);
      end
    end

    // Reach Nivel=120 with Desborde set, then reset mid-cycle
    repeat_step(8'b0100_0000, 25);
    repeat_step(8'b0001_0000, 4);
    @(posedge Clk);
    #3 Reset = 1'b1;
    model_reset();
    #2 chk_zero("async_reset");
    #1 Reset = 1'b0;
    repeat_step(8'b1000_0000, 3);
    repeat_step(8'b0000_0000, 1);

    @(posedge Clk);
    #2;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
